asteroid_spawner: RTL and testbench

Central spawn controller that drives the `new_asteroid`, `asteroid_hit` and `ast_type` inputs and the shared init buses of the `N_UNITS` asteroid units. It seeds a level with large asteroids and splits hit asteroids into two smaller children. It is the initiator of the spawn/kill protocol that each asteroid unit responds to. It sits between the collision logic (hit requests) and the asteroid unit array.

---
 rtl/asteroid_spawner.sv | 279 +++++++++++++++++++++++++++
 tb/tb_asteroid_spawner.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asteroid_spawner.sv
// Spawn controller: seeds waves of large asteroids and splits hit asteroids into two children.
// Optional `score` output and its scoring logic are enabled by defining ASTEROID_SPAWNER_SCORE_EN.
module asteroid_spawner #(
  parameter int          N_UNITS   = 8,
  parameter int          WIDTH     = 640,
  parameter int          HEIGHT    = 480,
  parameter int          XLARGE    = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         X_W       = $clog2(WIDTH),
  localparam int         Y_W       = $clog2(HEIGHT),
  localparam int         IDX_W     = $clog2(N_UNITS)
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   start_done,
  input  logic                   level_start,
  input  logic [3:0]             wave_count,
  input  logic                   hit_valid,
  input  logic [IDX_W-1:0]       hit_idx,
  output logic                   hit_ready,
  input  logic [N_UNITS*X_W-1:0] unit_x,
  input  logic [N_UNITS*Y_W-1:0] unit_y,
  output logic [N_UNITS-1:0]     new_asteroid,
  output logic [N_UNITS-1:0]     asteroid_hit,
  output logic [N_UNITS*2-1:0]   ast_type,
  output logic [X_W-1:0]         x_init,
  output logic [Y_W-1:0]         y_init,
  output logic [9:0]             phase_n,
  output logic [3:0]             phase_inc_n,
  output logic [N_UNITS-1:0]     active,
  output logic                   wave_clear
`ifdef ASTEROID_SPAWNER_SCORE_EN
  ,
  output logic [15:0]            score
`endif
);

  typedef enum logic [1:0] {AST_SMALL = 2'd0, AST_MED = 2'd1, AST_LARGE = 2'd2, AST_XLARGE = 2'd3} ast_t;
  typedef enum logic [2:0] {S_IDLE, S_WAVE, S_KILL, S_SPAWN_A, S_SPAWN_B} state_t;

  localparam logic [X_W:0] WIDTH_C  = (X_W+1)'(WIDTH);
  localparam logic [Y_W:0] HEIGHT_C = (Y_W+1)'(HEIGHT);
  localparam logic [4:0]   N_C      = 5'(N_UNITS);

  state_t             state_q, state_d;
  logic               lvl_pend_q, lvl_pend_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [N_UNITS-1:0] active_q, active_d;
  ast_t               ast_type_q [N_UNITS];
  ast_t               ast_type_d [N_UNITS];
  logic [4:0]         cnt_q, cnt_d;
  logic               k_odd_q, k_odd_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic [X_W-1:0]     hit_x_q, hit_x_d;
  logic [Y_W-1:0]     hit_y_q, hit_y_d;
  ast_t               child_q, child_d;
  logic [9:0]         phase_a_q, phase_a_d;
  logic [X_W-1:0]     x_init_q, x_init_d;
  logic [Y_W-1:0]     y_init_q, y_init_d;
  logic [9:0]         phase_q, phase_d;
  logic [3:0]         phase_inc_q, phase_inc_d;
  logic               wave_clear_q, wave_clear_d;

  logic [X_W-1:0]     unit_x_a [N_UNITS];
  logic [Y_W-1:0]     unit_y_a [N_UNITS];
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic [X_W-1:0]     x_mod;
  logic [Y_W-1:0]     y_mod;
  logic               spawn;
  ast_t               spawn_type;
  logic [X_W-1:0]     spawn_x;
  logic [Y_W-1:0]     spawn_y;
  logic [9:0]         spawn_phase;

  genvar gi;
  generate
    for (gi = 0; gi < N_UNITS; gi++) begin : g_slot
      assign unit_x_a[gi]           = unit_x[gi*X_W +: X_W];
      assign unit_y_a[gi]           = unit_y[gi*Y_W +: Y_W];
      assign ast_type[gi*2 +: 2]    = ast_type_q[gi];
    end
  endgenerate

  assign active      = active_q;
  assign wave_clear  = wave_clear_q;
  assign x_init      = x_init_d;
  assign y_init      = y_init_d;
  assign phase_n     = phase_d;
  assign phase_inc_n = phase_inc_d;
  assign hit_ready   = (state_q == S_IDLE) && start_done && !lvl_pend_q;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  assign x_mod = ({1'b0, lfsr_q[X_W-1:0]} >= WIDTH_C)
               ? X_W'({1'b0, lfsr_q[X_W-1:0]} - WIDTH_C) : lfsr_q[X_W-1:0];
  assign y_mod = ({1'b0, lfsr_q[Y_W-1:0]} >= HEIGHT_C)
               ? Y_W'({1'b0, lfsr_q[Y_W-1:0]} - HEIGHT_C) : lfsr_q[Y_W-1:0];

  // Lowest free slot wins: scan downward so the last hit is the lowest index
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_UNITS-1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lvl_pend_d   = lvl_pend_q | (level_start & start_done);
    active_d     = active_q;
    ast_type_d   = ast_type_q;
    cnt_d        = cnt_q;
    k_odd_d      = k_odd_q;
    hit_idx_d    = hit_idx_q;
    hit_x_d      = hit_x_q;
    hit_y_d      = hit_y_q;
    child_d      = child_q;
    phase_a_d    = phase_a_q;
    x_init_d     = x_init_q;
    y_init_d     = y_init_q;
    phase_d      = phase_q;
    phase_inc_d  = phase_inc_q;
    new_asteroid = '0;
    asteroid_hit = '0;
    spawn        = 1'b0;
    spawn_type   = AST_LARGE;
    spawn_x      = '0;
    spawn_y      = '0;
    spawn_phase  = lfsr_q[9:0];

    case (state_q)
      S_IDLE: begin
        if (hit_valid && hit_ready) begin
          state_d   = S_KILL;
          hit_idx_d = hit_idx;
          hit_x_d   = unit_x_a[hit_idx];
          hit_y_d   = unit_y_a[hit_idx];
        end else if (start_done && lvl_pend_q) begin
          state_d    = S_WAVE;
          lvl_pend_d = level_start & start_done;
          cnt_d      = ({1'b0, wave_count} > N_C) ? N_C : {1'b0, wave_count};
          k_odd_d    = 1'b0;
        end
      end
      S_WAVE: begin
        if (cnt_q == 5'd0 || !free_found) begin
          state_d = S_IDLE;
        end else begin
          spawn   = 1'b1;
          spawn_x = k_odd_q ? '0 : x_mod;
          spawn_y = k_odd_q ? y_mod : '0;
          cnt_d   = cnt_q - 5'd1;
          k_odd_d = ~k_odd_q;
        end
      end
      S_KILL: begin
        state_d = S_IDLE;
        if (active_q[hit_idx_q]) begin
          asteroid_hit[hit_idx_q] = 1'b1;
          active_d[hit_idx_q]     = 1'b0;
          case (ast_type_q[hit_idx_q])
            AST_LARGE: begin child_d = AST_MED;   state_d = S_SPAWN_A; end
            AST_MED:   begin child_d = AST_SMALL; state_d = S_SPAWN_A; end
            AST_XLARGE: begin
              if (XLARGE != 0) begin
                child_d = AST_LARGE;
                state_d = S_SPAWN_A;
              end
            end
            default: ;
          endcase
        end
      end
      S_SPAWN_A: begin
        phase_a_d  = lfsr_q[9:0];
        spawn      = free_found;
        spawn_type = child_q;
        spawn_x    = hit_x_q;
        spawn_y    = hit_y_q;
        state_d    = S_SPAWN_B;
      end
      S_SPAWN_B: begin
        spawn_phase = phase_a_q + 10'd512;
        spawn       = free_found;
        spawn_type  = child_q;
        spawn_x     = hit_x_q;
        spawn_y     = hit_y_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (spawn) begin
      new_asteroid[free_idx] = 1'b1;
      active_d[free_idx]     = 1'b1;
      ast_type_d[free_idx]   = spawn_type;
      x_init_d               = spawn_x;
      y_init_d               = spawn_y;
      phase_d                = spawn_phase;
      phase_inc_d            = lfsr_q[13:10];
    end

    wave_clear_d = (active_q != '0) && (active_d == '0);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      lvl_pend_q   <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      active_q     <= '0;
      for (int i = 0; i < N_UNITS; i++) ast_type_q[i] <= AST_LARGE;
      cnt_q        <= '0;
      k_odd_q      <= 1'b0;
      hit_idx_q    <= '0;
      hit_x_q      <= '0;
      hit_y_q      <= '0;
      child_q      <= AST_SMALL;
      phase_a_q    <= '0;
      x_init_q     <= '0;
      y_init_q     <= '0;
      phase_q      <= '0;
      phase_inc_q  <= '0;
      wave_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lvl_pend_q   <= lvl_pend_d;
      lfsr_q       <= lfsr_d;
      active_q     <= active_d;
      ast_type_q   <= ast_type_d;
      cnt_q        <= cnt_d;
      k_odd_q      <= k_odd_d;
      hit_idx_q    <= hit_idx_d;
      hit_x_q      <= hit_x_d;
      hit_y_q      <= hit_y_d;
      child_q      <= child_d;
      phase_a_q    <= phase_a_d;
      x_init_q     <= x_init_d;
      y_init_q     <= y_init_d;
      phase_q      <= phase_d;
      phase_inc_q  <= phase_inc_d;
      wave_clear_q <= wave_clear_d;
    end
  end

`ifdef ASTEROID_SPAWNER_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [7:0]  score_add;
  logic [16:0] score_sum;

  always_comb begin
    score_add = 8'd0;
    if (state_q == S_KILL && active_q[hit_idx_q]) begin
      case (ast_type_q[hit_idx_q])
        AST_LARGE: score_add = 8'd20;
        AST_MED:   score_add = 8'd50;
        AST_SMALL: score_add = 8'd100;
        default:   score_add = 8'd0;
      endcase
    end
    score_sum = {1'b0, score_q} + {9'd0, score_add};
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) score_q <= '0;
    else         score_q <= score_d;
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_asteroid_spawner.sv
// Directed self-checking bench for asteroid_spawner: table-driven wave/hit vectors plus
// hand-written split, drop, wave-clear and merge sequences.
module tb_asteroid_spawner;
  localparam int N  = 8;
  localparam int XW = 10;
  localparam int YW = 9;

  logic          clk = 1'b0;
  logic          resetN;
  logic          start_done;
  logic          level_start;
  logic [3:0]    wave_count;
  logic          hit_valid;
  logic [2:0]    hit_idx;
  logic          hit_ready;
  logic [N*XW-1:0] unit_x;
  logic [N*YW-1:0] unit_y;
  logic [N-1:0]  new_asteroid;
  logic [N-1:0]  asteroid_hit;
  logic [N*2-1:0] ast_type;
  logic [XW-1:0] x_init;
  logic [YW-1:0] y_init;
  logic [9:0]    phase_n;
  logic [3:0]    phase_inc_n;
  logic [N-1:0]  active;
  logic          wave_clear;
`ifdef ASTEROID_SPAWNER_SCORE_EN
  logic [15:0]   score;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  asteroid_spawner dut (
    .clk(clk), .resetN(resetN), .start_done(start_done), .level_start(level_start),
    .wave_count(wave_count), .hit_valid(hit_valid), .hit_idx(hit_idx), .hit_ready(hit_ready),
    .unit_x(unit_x), .unit_y(unit_y), .new_asteroid(new_asteroid), .asteroid_hit(asteroid_hit),
    .ast_type(ast_type), .x_init(x_init), .y_init(y_init), .phase_n(phase_n),
    .phase_inc_n(phase_inc_n), .active(active), .wave_clear(wave_clear)
`ifdef ASTEROID_SPAWNER_SCORE_EN
    , .score(score)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  typedef struct {
    logic       ls;
    logic       hv;
    logic [2:0] hi;
    logic [7:0] e_new;
    logic [7:0] e_hit;
    logic [7:0] e_act;
    logic       e_rdy;
    logic       e_wc;
    int         pos;   // 0 none, 1 top edge, 2 left edge, 3 at (100,200)
  } row_t;

  row_t tbl [12];
  logic [9:0] ph [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_pos(input int idx, input int x, input int y);
    unit_x[idx*XW +: XW] = XW'(x);
    unit_y[idx*YW +: YW] = YW'(y);
  endtask

  task automatic wait_ready(input string nm);
    int t = 0;
    while (!hit_ready && t < 40) begin
      @(negedge clk); #1;
      t++;
    end
    chk(nm, hit_ready, 1);
  endtask

  task automatic run_wave(input logic [3:0] wc);
    @(negedge clk);
    wave_count  = wc;
    level_start = 1'b1;
    @(negedge clk);
    level_start = 1'b0;
    #1;
    wait_ready("wave_done");
    $display("wave wc=%0d active=%02h", wc, active);
  endtask

  task automatic do_hit(input logic [2:0] idx);
    @(negedge clk);
    hit_valid = 1'b1;
    hit_idx   = idx;
    #1;
    chk("hs_ready", hit_ready, 1);
    @(negedge clk);
    hit_valid = 1'b0;
    #1;
    wait_ready("hit_done");
    $display("hit idx=%0d active=%02h", idx, active);
  endtask

  initial begin
    int cnt;
    int t;
    logic stray;

    tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1};
    tbl[3]  = '{1'b0, 1'b0, 3'd0, 8'h02, 8'h00, 8'h01, 1'b0, 1'b0, 2};
    tbl[4]  = '{1'b0, 1'b0, 3'd0, 8'h04, 8'h00, 8'h03, 1'b0, 1'b0, 1};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 8'h08, 8'h00, 8'h07, 1'b0, 1'b0, 2};
    tbl[6]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h0F, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b0, 1'b1, 3'd2, 8'h00, 8'h00, 8'h0F, 1'b1, 1'b0, 0};
    tbl[8]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h04, 8'h0F, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b0, 1'b0, 3'd0, 8'h04, 8'h00, 8'h0B, 1'b0, 1'b0, 3};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 8'h10, 8'h00, 8'h0F, 1'b0, 1'b0, 3};
    tbl[11] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h1F, 1'b1, 1'b0, 0};

    resetN = 1'b0; start_done = 1'b0; level_start = 1'b0; wave_count = 4'd4;
    hit_valid = 1'b0; hit_idx = '0; unit_x = '0; unit_y = '0;
    set_pos(2, 100, 200);
    #12;
    chk("rst_ready", hit_ready, 0);
    chk("rst_active", active, 0);
    chk("rst_new", new_asteroid, 0);
    chk("rst_hit", asteroid_hit, 0);
    chk("rst_type", ast_type, 16'hAAAA);
    chk("rst_x", x_init, 0);
    chk("rst_y", y_init, 0);
    chk("rst_phase", phase_n, 0);
    chk("rst_inc", phase_inc_n, 0);
    chk("rst_wc", wave_clear, 0);
`ifdef ASTEROID_SPAWNER_SCORE_EN
    chk("rst_score", score, 0);
`endif
    @(negedge clk); resetN = 1'b1;

    // level_start while the intro screen is up must be dropped
    @(negedge clk); level_start = 1'b1;
    @(negedge clk); level_start = 1'b0; start_done = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("intro_ready", hit_ready, 1);
    chk("intro_active", active, 0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      level_start = tbl[i].ls;
      hit_valid   = tbl[i].hv;
      hit_idx     = tbl[i].hi;
      #1;
      $display("row %0d new=%02h hit=%02h act=%02h rdy=%0b x=%0d y=%0d ph=%0d",
               i, new_asteroid, asteroid_hit, active, hit_ready, x_init, y_init, phase_n);
      chk($sformatf("row%0d_new", i), new_asteroid, tbl[i].e_new);
      chk($sformatf("row%0d_hit", i), asteroid_hit, tbl[i].e_hit);
      chk($sformatf("row%0d_act", i), active, tbl[i].e_act);
      chk($sformatf("row%0d_rdy", i), hit_ready, tbl[i].e_rdy);
      chk($sformatf("row%0d_wc", i), wave_clear, tbl[i].e_wc);
      ph[i] = phase_n;
      if (tbl[i].pos == 1) begin
        chk($sformatf("row%0d_y0", i), y_init, 0);
        chk($sformatf("row%0d_xrng", i), x_init < 640, 1);
      end else if (tbl[i].pos == 2) begin
        chk($sformatf("row%0d_x0", i), x_init, 0);
        chk($sformatf("row%0d_yrng", i), y_init < 480, 1);
      end else if (tbl[i].pos == 3) begin
        chk($sformatf("row%0d_x", i), x_init, 100);
        chk($sformatf("row%0d_y", i), y_init, 200);
      end
    end
    chk("phase_b", ph[10], 10'(ph[9] + 10'd512));
    chk("split_types", ast_type, 16'hA99A);
    chk("x_hold", x_init, 100);
`ifdef ASTEROID_SPAWNER_SCORE_EN
    chk("score_tbl", score, 20);
`endif

    // asynchronous reset in the middle of operation
    @(negedge clk); resetN = 1'b0;
    #1;
    chk("arst_active", active, 0);
    chk("arst_type", ast_type, 16'hAAAA);
    chk("arst_x", x_init, 0);
    chk("arst_phase", phase_n, 0);
    @(negedge clk); resetN = 1'b1;

    run_wave(4'd1);
    chk("w1_active", active, 8'h01);
    do_hit(3'd0);
    chk("k0_active", active, 8'h03);
`ifdef ASTEROID_SPAWNER_SCORE_EN
    chk("score_large", score, 20);
`endif
    do_hit(3'd1);
    chk("k1_active", active, 8'h07);
`ifdef ASTEROID_SPAWNER_SCORE_EN
    chk("score_med", score, 70);
`endif
    do_hit(3'd1);
    chk("k2_active", active, 8'h05);
`ifdef ASTEROID_SPAWNER_SCORE_EN
    chk("score_small", score, 170);
`endif
    do_hit(3'd0);
    chk("k3_active", active, 8'h07);
    do_hit(3'd0);
    do_hit(3'd1);
    chk("k5_active", active, 8'h04);

    // last SMALL killed: no children, wave_clear fires, ready at T+2
    @(negedge clk); hit_valid = 1'b1; hit_idx = 3'd2;
    #1; chk("last_hs", hit_ready, 1);
    @(negedge clk); hit_valid = 1'b0;
    #1;
    chk("last_hit", asteroid_hit, 8'h04);
    chk("last_new1", new_asteroid, 0);
    @(negedge clk); #1;
    $display("last T+2 new=%02h act=%02h wc=%0b rdy=%0b", new_asteroid, active, wave_clear, hit_ready);
    chk("last_new2", new_asteroid, 0);
    chk("last_active", active, 0);
    chk("last_wc", wave_clear, 1);
    chk("last_ready", hit_ready, 1);
    @(negedge clk); #1;
    chk("last_wc_off", wave_clear, 0);

    // hit on an empty slot merged with a wave request of 9 into 8 slots
    @(negedge clk); hit_valid = 1'b1; hit_idx = 3'd5; level_start = 1'b1; wave_count = 4'd9;
    #1; chk("mrg_hs", hit_ready, 1);
    @(negedge clk); hit_valid = 1'b0; level_start = 1'b0;
    #1;
    chk("mrg_hit", asteroid_hit, 0);
    chk("mrg_new1", new_asteroid, 0);
    @(negedge clk); #1;
    chk("mrg_rdy2", hit_ready, 0);
    chk("mrg_new2", new_asteroid, 0);
    @(negedge clk); #1;
    chk("mrg_first", new_asteroid, 8'h01);
    cnt = 0; t = 0; stray = 1'b0;
    while (!hit_ready && t < 30) begin
      if (new_asteroid != '0) cnt++;
      if (asteroid_hit != '0) stray = 1'b1;
      @(negedge clk); #1;
      t++;
    end
    $display("merge spawns=%0d active=%02h", cnt, active);
    chk("mrg_ready", hit_ready, 1);
    chk("mrg_count", cnt, 8);
    chk("mrg_stray", stray, 0);
    chk("mrg_active", active, 8'hFF);

    // full array: only child A lands, child B dropped
    set_pos(3, 300, 50);
    @(negedge clk); hit_valid = 1'b1; hit_idx = 3'd3;
    #1; chk("full_hs", hit_ready, 1);
    @(negedge clk); hit_valid = 1'b0;
    #1; chk("full_hit", asteroid_hit, 8'h08);
    @(negedge clk); #1;
    chk("full_newA", new_asteroid, 8'h08);
    chk("full_xA", x_init, 300);
    chk("full_yA", y_init, 50);
    @(negedge clk); #1;
    chk("full_newB", new_asteroid, 0);
    chk("full_act", active, 8'hFF);
    chk("full_xhold", x_init, 300);
    @(negedge clk); #1;
    chk("full_ready", hit_ready, 1);
    chk("full_typeA", ast_type[7:6], 2'd1);
    do_hit(3'd3);
    chk("full_med_act", active, 8'hFF);
    chk("full_typeS", ast_type[7:6], 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
